regfile_scoreboard: RTL

Parametrised successor to the 32x32 register file for the pipelined OTTER core. Holds `NREGS` general registers of `XLEN` bits, with two asynchronous read ports and one synchronous write-back port. Adds a per-register pending (scoreboard) bit, set when an instruction writing that register issues and cleared at write-back. Decode uses the resulting `stall` for RAW/WAW hazard interlock; the block sits between decode and write-back.

---
 rtl/regfile_scoreboard_if.sv | 36 +++
 rtl/regfile_scoreboard.sv | 85 ++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode / write-back connection to the scoreboarded register file.
// master = decode and write-back stages, slave = regfile_scoreboard.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   rd_addr1;
    logic [AW-1:0]   rd_addr2;
    logic            rd_use1;
    logic            rd_use2;
    logic [XLEN-1:0] rd_data1;
    logic [XLEN-1:0] rd_data2;
    logic            rd_busy1;
    logic            rd_busy2;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            stall;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [AW:0]     pending_cnt;

    modport master (
        output rd_addr1, rd_addr2, rd_use1, rd_use2,
        output issue_en, issue_addr, wb_en, wb_addr, wb_data,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, stall, pending_cnt
    );

    modport slave (
        input  rd_addr1, rd_addr2, rd_use1, rd_use2,
        input  issue_en, issue_addr, wb_en, wb_addr, wb_data,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, stall, pending_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// NREGS x XLEN register file (x0 = 0) with per-register pending bits for RAW/WAW interlock.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to reads and hazard checks.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic                 CLK,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic [CW-1:0]    cnt;

    logic wb_hit;
    logic fwd1;
    logic fwd2;
    logic fwd_issue;
    logic busy1;
    logic busy2;
    logic waw;
    logic stall;
    logic accept;
    logic inc;
    logic dec;

    assign wb_hit = bus.wb_en && (bus.wb_addr != '0);

`ifdef REGFILE_BYPASS_EN
    assign fwd1      = wb_hit && (bus.wb_addr == bus.rd_addr1);
    assign fwd2      = wb_hit && (bus.wb_addr == bus.rd_addr2);
    assign fwd_issue = wb_hit && (bus.wb_addr == bus.issue_addr);
`else
    assign fwd1      = 1'b0;
    assign fwd2      = 1'b0;
    assign fwd_issue = 1'b0;
`endif

    assign bus.rd_data1 = (bus.rd_addr1 == '0) ? '0 : (fwd1 ? bus.wb_data : mem[bus.rd_addr1]);
    assign bus.rd_data2 = (bus.rd_addr2 == '0) ? '0 : (fwd2 ? bus.wb_data : mem[bus.rd_addr2]);

    // pending[0] is never set, so x0 can never report busy
    assign busy1 = pending[bus.rd_addr1] && !fwd1;
    assign busy2 = pending[bus.rd_addr2] && !fwd2;
    assign waw   = (bus.issue_addr != '0) && pending[bus.issue_addr] && !fwd_issue;

    assign stall  = bus.issue_en && ((bus.rd_use1 && busy1) || (bus.rd_use2 && busy2) || waw);
    assign accept = bus.issue_en && !stall && (bus.issue_addr != '0);

    assign bus.rd_busy1    = busy1;
    assign bus.rd_busy2    = busy2;
    assign bus.stall       = stall;
    assign bus.pending_cnt = cnt;

    // A same-register clear and re-set nets to zero change in the count
    assign inc = accept && !pending[bus.issue_addr];
    assign dec = wb_hit && pending[bus.wb_addr] && !(accept && (bus.issue_addr == bus.wb_addr));

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        pending_next = pending;
        if (wb_hit) pending_next[bus.wb_addr] = 1'b0;
        if (accept) pending_next[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            // NOTE: the array is flops, not RAM, so clearing every entry on reset is legal and required.
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            pending <= '0;
            cnt     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            if (wb_hit) mem[bus.wb_addr] <= bus.wb_data;
            pending <= pending_next;
            cnt     <= cnt + CW'(inc) - CW'(dec);
        end
    end
endmodule
